alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter RS_SIZE, default 8, number of reservation-station entries feeding the ALU.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  global ready; low = freeze all state.
REQ-005 clear  input  1  pipeline flush on branch/JALR mispredict.
REQ-006 disp_valid  input  1  dispatch request this cycle.
REQ-007 disp_type  input  OP_WIDTH  encoded op, passed unchanged to the ALU.
REQ-008 disp_qj_busy, disp_qk_busy  input  1 each  operand j/k still waiting on a ROB tag.
REQ-009 disp_qj, disp_qk  input  ROB_ID_WIDTH+1 each  producer ROB tag of operand j/k.
REQ-010 disp_vj, disp_vk  input  VAL_WIDTH each  operand values, valid when the matching busy bit is 0.
REQ-011 disp_entry  input  ROB_ID_WIDTH+1  destination ROB tag.
REQ-012 disp_pc  input  ADDR_WIDTH  instruction PC, forwarded as nowPC.
REQ-013 rs_full  output  1  no free entry; dispatch is refused.
REQ-014 cdb_alu_valid/cdb_alu_tag/cdb_alu_val  input  1/ROB_ID_WIDTH+1/VAL_WIDTH  ALU result broadcast.
REQ-015 cdb_lsb_valid/cdb_lsb_tag/cdb_lsb_val  input  1/ROB_ID_WIDTH+1/VAL_WIDTH  load-store result broadcast.
REQ-016 execute, type, val1, val2, entry, nowPC  output  1/OP_WIDTH/VAL_WIDTH/VAL_WIDTH/ROB_ID_WIDTH+1/ADDR_WIDTH  registered ALU issue bundle.

Function
REQ-017 Each entry SHALL hold busy, type, qj_busy, qj, vj, qk_busy, qk, vk, entry tag, pc.
REQ-018 rs_full SHALL be combinational: 1 exactly when all RS_SIZE entries are busy, from the current registered state.
REQ-019 Dispatch with disp_valid=1 and rs_full=0 SHALL write the lowest-index free entry; dispatch while rs_full=1 SHALL be dropped without changing state.
REQ-020 A dispatched operand whose busy tag matches a valid CDB broadcast in the same cycle SHALL be stored as ready with that CDB value. When both CDB ports match, the ALU port value SHALL be used.
REQ-021 Every cycle, each busy entry with a waiting operand whose tag matches a valid CDB port SHALL capture the value and clear its busy bit.
REQ-022 An entry SHALL be issuable when it is busy and both qj_busy and qk_busy are 0 in registered state. Operands captured this cycle make the entry issuable next cycle.
REQ-023 Each cycle the lowest-index issuable entry SHALL be selected. On the next edge its fields SHALL be registered onto type/val1=vj/val2=vk/entry/nowPC, execute SHALL be set to 1, and the entry SHALL be freed.
REQ-024 When no entry is issuable, execute SHALL be 0 for that following cycle. Other issue outputs SHALL hold their last values.
REQ-025 Issue-to-execute latency SHALL be exactly 1 cycle. Sustained throughput SHALL be one issue per cycle.
REQ-026 A slot freed by issue SHALL be reusable by dispatch no earlier than the next cycle.
REQ-027 Simultaneous dispatch and issue when full SHALL issue and refuse the dispatch.
REQ-028 clear=1 SHALL, on the edge, free all entries and force execute to 0. clear SHALL take priority over dispatch, capture and issue.
REQ-029 rdy_in=0 SHALL hold every register, including execute and the issue bundle. Dispatch and CDB inputs in that cycle SHALL be ignored.

Reset
REQ-030 rst_in low SHALL immediately clear all busy bits and drive execute, type, val1, val2, entry and nowPC to 0. rs_full SHALL then read 0.
REQ-031 Reset asserted mid-operation SHALL discard all pending entries. The first dispatch after release SHALL go to entry 0.

Structure
REQ-032 OP_WIDTH, VAL_WIDTH, ADDR_WIDTH, ROB_ID_WIDTH, RS_SIZE and RS_ID_WIDTH SHALL come from the shared util.v constants.
REQ-033 One sub-module, rs_prio_enc, SHALL provide lowest-index selection over an RS_SIZE-bit vector, returning a found flag and an index. It SHALL be instantiated twice, for the free slot and the ready slot.

Verification
REQ-034 Dispatch addi (vj=5, vk=7, both ready, entry=3) into an empty RS -> next cycle execute=1, val1=5, val2=7, entry=3. The cycle after -> execute=0.
REQ-035 Dispatch with qj=2 waiting. Two cycles later cdb_lsb broadcasts tag 2 with value 0x10 -> the cycle after the capture, execute=1 and val1=0x10.
REQ-036 Dispatch with qk=4 while cdb_alu broadcasts tag 4 with value 9 in the same cycle -> issue next cycle with val2=9.
REQ-037 Fill 8 entries, all waiting -> rs_full=1 and a 9th dispatch is dropped. Release the tag of entry 5 -> entry 5 issues, rs_full=0 the following cycle, and the next dispatch lands in slot 5.
REQ-038 Entries 1 and 6 ready together -> entry 1 issues first, entry 6 on the next cycle.
REQ-039 Assert clear with 3 entries busy and dispatch active -> next cycle execute=0, rs_full=0, no stale issue. Hold rdy_in=0 for 3 cycles -> outputs frozen.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared widths, reservation-station entry layout and the CDB operand-capture
// helper used by the ALU reservation station.
package alu_rs_pkg;

  localparam int OP_WIDTH     = 6;
  localparam int VAL_WIDTH    = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int ROB_ID_WIDTH = 4;
  localparam int ROB_TAG_W    = ROB_ID_WIDTH + 1;
  localparam int RS_SIZE      = 8;
  localparam int RS_ID_WIDTH  = 3;

  typedef struct packed {
    logic                 busy;
    logic [ROB_TAG_W-1:0] tag;
    logic [VAL_WIDTH-1:0] val;
  } operand_t;

  typedef struct packed {
    logic                  busy;
    logic [OP_WIDTH-1:0]   op_type;
    operand_t              qj;
    operand_t              qk;
    logic [ROB_TAG_W-1:0]  entry;
    logic [ADDR_WIDTH-1:0] pc;
  } rs_entry_t;

  // A waiting operand takes the value of a matching broadcast; the ALU port wins a tie.
  function automatic operand_t cdb_snoop(
    input operand_t             op,
    input logic                 alu_valid,
    input logic [ROB_TAG_W-1:0] alu_tag,
    input logic [VAL_WIDTH-1:0] alu_val,
    input logic                 lsb_valid,
    input logic [ROB_TAG_W-1:0] lsb_tag,
    input logic [VAL_WIDTH-1:0] lsb_val
  );
    operand_t res;
    res = op;
    if (op.busy && alu_valid && (alu_tag == op.tag)) begin
      res.busy = 1'b0;
      res.val  = alu_val;
    end else if (op.busy && lsb_valid && (lsb_tag == op.tag)) begin
      res.busy = 1'b0;
      res.val  = lsb_val;
    end else begin
      res = op;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-index set-bit selector: reports whether any bit is set and which one.
module rs_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = vec[i] ? W'(i) : idx;
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are known,
// snoops both CDB ports, and issues one ready op per cycle to the ALU.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = alu_rs_pkg::RS_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  input  logic                  disp_valid,
  input  logic [OP_WIDTH-1:0]   disp_type,
  input  logic                  disp_qj_busy,
  input  logic                  disp_qk_busy,
  input  logic [ROB_TAG_W-1:0]  disp_qj,
  input  logic [ROB_TAG_W-1:0]  disp_qk,
  input  logic [VAL_WIDTH-1:0]  disp_vj,
  input  logic [VAL_WIDTH-1:0]  disp_vk,
  input  logic [ROB_TAG_W-1:0]  disp_entry,
  input  logic [ADDR_WIDTH-1:0] disp_pc,
  output logic                  rs_full,
  input  logic                  cdb_alu_valid,
  input  logic [ROB_TAG_W-1:0]  cdb_alu_tag,
  input  logic [VAL_WIDTH-1:0]  cdb_alu_val,
  input  logic                  cdb_lsb_valid,
  input  logic [ROB_TAG_W-1:0]  cdb_lsb_tag,
  input  logic [VAL_WIDTH-1:0]  cdb_lsb_val,
  output logic                  execute,
  output logic [OP_WIDTH-1:0]   alu_type,
  output logic [VAL_WIDTH-1:0]  val1,
  output logic [VAL_WIDTH-1:0]  val2,
  output logic [ROB_TAG_W-1:0]  entry,
  output logic [ADDR_WIDTH-1:0] nowPC
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry_t             rs_r     [RS_SIZE];
  rs_entry_t             rs_nxt_s [RS_SIZE];
  rs_entry_t             new_entry_s;
  logic [RS_SIZE-1:0]    free_vec_s;
  logic [RS_SIZE-1:0]    ready_vec_s;
  logic                  free_found_s;
  logic                  ready_found_s;
  logic [IDX_W-1:0]      free_idx_s;
  logic [IDX_W-1:0]      ready_idx_s;
  logic                  do_disp_s;

  logic                  execute_r;
  logic [OP_WIDTH-1:0]   type_r;
  logic [VAL_WIDTH-1:0]  val1_r;
  logic [VAL_WIDTH-1:0]  val2_r;
  logic [ROB_TAG_W-1:0]  entry_r;
  logic [ADDR_WIDTH-1:0] pc_r;

  // Free and issuable slot vectors, both taken from registered state only.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec_s[i]  = ~rs_r[i].busy;
      ready_vec_s[i] = rs_r[i].busy & ~rs_r[i].qj.busy & ~rs_r[i].qk.busy;
    end
  end

  assign rs_full   = ~(|free_vec_s);
  assign do_disp_s = disp_valid & free_found_s;

  rs_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_free_enc (
    .vec   (free_vec_s),
    .found (free_found_s),
    .idx   (free_idx_s)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_ready_enc (
    .vec   (ready_vec_s),
    .found (ready_found_s),
    .idx   (ready_idx_s)
  );

  // Incoming entry, with operands that the CDB resolves in the dispatch cycle.
  always_comb begin
    new_entry_s.busy    = 1'b1;
    new_entry_s.op_type = disp_type;
    new_entry_s.qj      = cdb_snoop('{busy: disp_qj_busy, tag: disp_qj, val: disp_vj},
                                    cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                    cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
    new_entry_s.qk      = cdb_snoop('{busy: disp_qk_busy, tag: disp_qk, val: disp_vk},
                                    cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                    cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
    new_entry_s.entry   = disp_entry;
    new_entry_s.pc      = disp_pc;
  end

  // Per-slot next state: the issuing slot frees, the chosen free slot loads, busy slots snoop.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      rs_nxt_s[i] = rs_r[i];
      if (ready_found_s && (ready_idx_s == IDX_W'(i))) begin
        rs_nxt_s[i].busy = 1'b0;
      end else if (do_disp_s && (free_idx_s == IDX_W'(i))) begin
        rs_nxt_s[i] = new_entry_s;
      end else if (rs_r[i].busy) begin
        rs_nxt_s[i].qj = cdb_snoop(rs_r[i].qj, cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                   cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
        rs_nxt_s[i].qk = cdb_snoop(rs_r[i].qk, cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                   cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
      end else begin
        rs_nxt_s[i] = rs_r[i];
      end
    end
  end

  // Entry storage; a flush empties every slot, a stalled pipeline holds everything.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        rs_r[i] <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        rs_r[i] <= clear ? '0 : rs_nxt_s[i];
      end
    end
  end

  // Issue bundle register; payload holds its last value when nothing issues.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      execute_r <= 1'b0;
      type_r    <= '0;
      val1_r    <= '0;
      val2_r    <= '0;
      entry_r   <= '0;
      pc_r      <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        execute_r <= 1'b0;
      end else if (ready_found_s) begin
        execute_r <= 1'b1;
        type_r    <= rs_r[ready_idx_s].op_type;
        val1_r    <= rs_r[ready_idx_s].qj.val;
        val2_r    <= rs_r[ready_idx_s].qk.val;
        entry_r   <= rs_r[ready_idx_s].entry;
        pc_r      <= rs_r[ready_idx_s].pc;
      end else begin
        execute_r <= 1'b0;
      end
    end
  end

  assign execute  = execute_r;
  assign alu_type = type_r;
  assign val1     = val1_r;
  assign val2     = val2_r;
  assign entry    = entry_r;
  assign nowPC    = pc_r;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed dispatch/CDB sequences push expected
// issue bundles; a monitor pops and compares on every new issue.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int TW = ROB_TAG_W;
  localparam int BW = OP_WIDTH + 2 * VAL_WIDTH + TW + ADDR_WIDTH;

  logic                  clk;
  logic                  rst_in;
  logic                  rdy_in;
  logic                  clear;
  logic                  disp_valid;
  logic [OP_WIDTH-1:0]   disp_type;
  logic                  disp_qj_busy;
  logic                  disp_qk_busy;
  logic [TW-1:0]         disp_qj;
  logic [TW-1:0]         disp_qk;
  logic [VAL_WIDTH-1:0]  disp_vj;
  logic [VAL_WIDTH-1:0]  disp_vk;
  logic [TW-1:0]         disp_entry;
  logic [ADDR_WIDTH-1:0] disp_pc;
  logic                  rs_full;
  logic                  cdb_alu_valid;
  logic [TW-1:0]         cdb_alu_tag;
  logic [VAL_WIDTH-1:0]  cdb_alu_val;
  logic                  cdb_lsb_valid;
  logic [TW-1:0]         cdb_lsb_tag;
  logic [VAL_WIDTH-1:0]  cdb_lsb_val;
  logic                  execute;
  logic [OP_WIDTH-1:0]   alu_type;
  logic [VAL_WIDTH-1:0]  val1;
  logic [VAL_WIDTH-1:0]  val2;
  logic [TW-1:0]         entry;
  logic [ADDR_WIDTH-1:0] nowPC;

  alu_rs dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .disp_valid(disp_valid), .disp_type(disp_type),
    .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_entry(disp_entry), .disp_pc(disp_pc), .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
    .execute(execute), .alu_type(alu_type), .val1(val1), .val2(val2),
    .entry(entry), .nowPC(nowPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] exp_q [$];
  string         ck_name_q [$];
  logic [31:0]   ck_act_q [$];
  logic [31:0]   ck_exp_q [$];
  int            tests = 0;
  int            fails = 0;
  logic          rdy_smp;
  logic [BW-1:0] mon_e;
  string         mon_n;
  logic [31:0]   mon_a;
  logic [31:0]   mon_x;

  function automatic logic [BW-1:0] bundle(input logic [OP_WIDTH-1:0] t,
                                           input logic [VAL_WIDTH-1:0] v1,
                                           input logic [VAL_WIDTH-1:0] v2,
                                           input logic [TW-1:0] e,
                                           input logic [ADDR_WIDTH-1:0] pc);
    return {t, v1, v2, e, pc};
  endfunction

  task automatic post(input string n, input logic [31:0] a, input logic [31:0] x);
    ck_name_q.push_back(n);
    ck_act_q.push_back(a);
    ck_exp_q.push_back(x);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    disp_valid    = 1'b0;
    cdb_alu_valid = 1'b0;
    cdb_lsb_valid = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic disp(input logic [OP_WIDTH-1:0] t, input logic qjb, input logic [TW-1:0] qj,
                      input logic [VAL_WIDTH-1:0] vj, input logic qkb, input logic [TW-1:0] qk,
                      input logic [VAL_WIDTH-1:0] vk, input logic [TW-1:0] e,
                      input logic [ADDR_WIDTH-1:0] pc);
    disp_valid   = 1'b1;
    disp_type    = t;
    disp_qj_busy = qjb;
    disp_qj      = qj;
    disp_vj      = vj;
    disp_qk_busy = qkb;
    disp_qk      = qk;
    disp_vk      = vk;
    disp_entry   = e;
    disp_pc      = pc;
  endtask

  task automatic cdb_alu(input logic [TW-1:0] t, input logic [VAL_WIDTH-1:0] v);
    cdb_alu_valid = 1'b1;
    cdb_alu_tag   = t;
    cdb_alu_val   = v;
  endtask

  task automatic cdb_lsb(input logic [TW-1:0] t, input logic [VAL_WIDTH-1:0] v);
    cdb_lsb_valid = 1'b1;
    cdb_lsb_tag   = t;
    cdb_lsb_val   = v;
  endtask

  // Monitor: every new issue pops one expected bundle; queued directed checks are drained too.
  always @(posedge clk) begin
    rdy_smp = rdy_in;
    #1;
    if (rst_in && rdy_smp && execute) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue act entry=%0d val1=%h required no issue", entry, val1);
      end else begin
        mon_e = exp_q.pop_front();
        if ({alu_type, val1, val2, entry, nowPC} !== mon_e) begin
          fails++;
          $display("FAIL issue_bundle act=%h required=%h",
                   {alu_type, val1, val2, entry, nowPC}, mon_e);
        end
      end
    end
    while (ck_name_q.size() > 0) begin
      mon_n = ck_name_q.pop_front();
      mon_a = ck_act_q.pop_front();
      mon_x = ck_exp_q.pop_front();
      tests++;
      if (mon_a !== mon_x) begin
        fails++;
        $display("FAIL %s act=%h required=%h", mon_n, mon_a, mon_x);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout act=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    disp_type = '0; disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_qj = '0; disp_qk = '0;
    disp_vj = '0; disp_vk = '0; disp_entry = '0; disp_pc = '0;
    cdb_alu_tag = '0; cdb_alu_val = '0; cdb_lsb_tag = '0; cdb_lsb_val = '0;
    idle_in();
    #1 rst_in = 1'b0;
    step(); step();
    post("rst_execute", 32'(execute), 32'd0);
    post("rst_rs_full", 32'(rs_full), 32'd0);
    post("rst_type",    32'(alu_type), 32'd0);
    post("rst_val1",    val1, 32'd0);
    post("rst_val2",    val2, 32'd0);
    post("rst_entry",   32'(entry), 32'd0);
    post("rst_nowpc",   nowPC, 32'd0);
    rst_in = 1'b1;
    step();

    // Both operands ready at dispatch.
    disp(6'd1, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd7, 5'd3, 32'h100);
    exp_q.push_back(bundle(6'd1, 32'd5, 32'd7, 5'd3, 32'h100));
    step(); idle_in();
    post("t1_exec_before", 32'(execute), 32'd0);
    step();
    post("t1_exec", 32'(execute), 32'd1);
    post("t1_val1", val1, 32'd5);
    post("t1_entry", 32'(entry), 32'd3);
    step();
    post("t1_exec_drop", 32'(execute), 32'd0);

    // vj waits on tag 2, released by the load-store port two cycles later.
    disp(6'd2, 1'b1, 5'd2, 32'hBAD, 1'b0, 5'd0, 32'd3, 5'd6, 32'h200);
    step(); idle_in();
    step();
    cdb_lsb(5'd2, 32'h10);
    exp_q.push_back(bundle(6'd2, 32'h10, 32'd3, 5'd6, 32'h200));
    step(); idle_in();
    post("t2_exec_capture", 32'(execute), 32'd0);
    step();
    post("t2_exec", 32'(execute), 32'd1);
    post("t2_val1", val1, 32'h10);
    step();

    // vk resolved in the dispatch cycle, both ports match: ALU value wins.
    disp(6'd3, 1'b0, 5'd0, 32'd1, 1'b1, 5'd4, 32'hDEAD, 5'd7, 32'h300);
    cdb_alu(5'd4, 32'd9);
    cdb_lsb(5'd4, 32'h55);
    exp_q.push_back(bundle(6'd3, 32'd1, 32'd9, 5'd7, 32'h300));
    step(); idle_in();
    step();
    post("t3_exec", 32'(execute), 32'd1);
    post("t3_val2", val2, 32'd9);
    step();

    // Fill all slots with ops waiting on tags 10..17.
    for (int i = 0; i < 8; i++) begin
      disp(6'd4, 1'b1, TW'(10 + i), 32'd0, 1'b0, 5'd0, 32'(i), TW'(20 + i), 32'h400 + 32'(i));
      step();
    end
    idle_in();
    post("t4_full", 32'(rs_full), 32'd1);
    disp(6'd4, 1'b0, 5'd0, 32'h99, 1'b0, 5'd0, 32'h98, 5'd30, 32'h4FF);
    step(); idle_in();
    post("t4_full_drop", 32'(rs_full), 32'd1);
    post("t4_no_issue", 32'(execute), 32'd0);
    cdb_alu(5'd15, 32'h55);
    exp_q.push_back(bundle(6'd4, 32'h55, 32'd5, 5'd25, 32'h405));
    step(); idle_in();
    post("t4_full_capture", 32'(rs_full), 32'd1);
    post("t4_exec_capture", 32'(execute), 32'd0);
    step();
    post("t4_exec_slot5", 32'(execute), 32'd1);
    post("t4_not_full", 32'(rs_full), 32'd0);
    disp(6'd5, 1'b0, 5'd0, 32'h77, 1'b0, 5'd0, 32'h78, 5'd31, 32'h500);
    exp_q.push_back(bundle(6'd5, 32'h77, 32'h78, 5'd31, 32'h500));
    step(); idle_in();
    post("t4_refull", 32'(rs_full), 32'd1);
    step();
    post("t4_reuse_entry", 32'(entry), 32'd31);
    post("t4_free_again", 32'(rs_full), 32'd0);

    // Slots 1 and 6 become ready together: lower index first.
    cdb_alu(5'd11, 32'h11);
    cdb_lsb(5'd16, 32'h16);
    exp_q.push_back(bundle(6'd4, 32'h11, 32'd1, 5'd21, 32'h401));
    exp_q.push_back(bundle(6'd4, 32'h16, 32'd6, 5'd26, 32'h406));
    step(); idle_in();
    step();
    post("t5_first", 32'(entry), 32'd21);
    step();
    post("t5_second_exec", 32'(execute), 32'd1);
    post("t5_second", 32'(entry), 32'd26);
    step();
    post("t5_idle", 32'(execute), 32'd0);

    // Drain slots 0 and 2, leaving three waiting entries.
    cdb_alu(5'd10, 32'hA0);
    cdb_lsb(5'd12, 32'hC0);
    exp_q.push_back(bundle(6'd4, 32'hA0, 32'd0, 5'd20, 32'h400));
    exp_q.push_back(bundle(6'd4, 32'hC0, 32'd2, 5'd22, 32'h402));
    step(); idle_in();
    step(); step(); step();

    // Flush with a dispatch and a broadcast in the same cycle.
    clear = 1'b1;
    disp(6'd6, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd2, 5'd9, 32'h600);
    cdb_alu(5'd13, 32'h13);
    step(); idle_in();
    post("clr_exec", 32'(execute), 32'd0);
    post("clr_full", 32'(rs_full), 32'd0);
    cdb_alu(5'd14, 32'h14);
    cdb_lsb(5'd17, 32'h17);
    step(); idle_in();
    step(); step();
    post("clr_no_stale", 32'(execute), 32'd0);

    // Freeze while an issue is on the outputs; inputs during the freeze are ignored.
    disp(6'd7, 1'b0, 5'd0, 32'hAB, 1'b0, 5'd0, 32'hCD, 5'd9, 32'h700);
    exp_q.push_back(bundle(6'd7, 32'hAB, 32'hCD, 5'd9, 32'h700));
    step(); idle_in();
    step();
    rdy_in = 1'b0;
    disp(6'd8, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd2, 5'd10, 32'h800);
    for (int k = 0; k < 3; k++) begin
      step();
      post("frz_exec", 32'(execute), 32'd1);
      post("frz_val1", val1, 32'hAB);
      post("frz_entry", 32'(entry), 32'd9);
    end
    rdy_in = 1'b1;
    idle_in();
    step();
    post("frz_release", 32'(execute), 32'd0);
    step();

    // Reset with waiting entries pending: they must never issue afterwards.
    disp(6'd9, 1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 32'h900);
    step();
    disp(6'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'd0, 5'd2, 32'h904);
    step(); idle_in();
    rst_in = 1'b0;
    step();
    post("mid_rst_full", 32'(rs_full), 32'd0);
    post("mid_rst_exec", 32'(execute), 32'd0);
    rst_in = 1'b1;
    disp(6'd10, 1'b0, 5'd0, 32'h31, 1'b0, 5'd0, 32'h32, 5'd12, 32'h908);
    exp_q.push_back(bundle(6'd10, 32'h31, 32'h32, 5'd12, 32'h908));
    step(); idle_in();
    step();
    post("mid_rst_issue", 32'(entry), 32'd12);
    cdb_alu(5'd1, 32'h1);
    cdb_lsb(5'd2, 32'h2);
    step(); idle_in();
    step(); step(); step();
    post("queue_drained", 32'(exp_q.size()), 32'd0);
    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
